// File: rtl/simon_pkg.sv
// SIMON32/64 shared constants and helpers.
// Holds the fixed cipher geometry (16-bit words, 4 key words, 32 rounds),
// the z0 round-constant sequence, the key-schedule constant C, and the
// word rotation and round function f() used by the datapath.
package simon_pkg;

    localparam int WORD_W     = 16;
    localparam int KEY_WORDS  = 4;
    localparam int NUM_ROUNDS = 32;

    // z0 sequence with bit i holding sequence element i.
    // The literal is the published sequence written back-to-front, so that
    // the first sequence element ends up at the LSB.
    localparam logic [61:0] Z0 =
        62'b01_1001110000_1101010010_0010111110_1100111000_0110101001_0001011111;

    // ~k0 ^ 3 is folded into k0 ^ C.
    localparam logic [WORD_W-1:0] C = 16'hFFFC;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] w, input int n);
        return (w << n) | (w >> (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] w, input int n);
        return (w >> n) | (w << (WORD_W - n));
    endfunction

    // SIMON round function: (x<<<1 & x<<<8) ^ x<<<2
    function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] x);
        return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
    endfunction

endpackage

// File: rtl/simon_key_schedule.sv
// SIMON32/64 on-the-fly key schedule.
// Holds the four live key words k0..k3 and advances them by one word per
// round. The round key consumed by the datapath is always k0.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   load       - capture a fresh key instead of advancing
//   key        - {k3,k2,k1,k0}
//   count      - round index selecting the z0 bit for this round
//   round_key  - k0, the key for the round performed this cycle
module simon_key_schedule
    import simon_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [63:0]         key,
    input  logic [4:0]          count,
    output logic [WORD_W-1:0]   round_key
);

    logic [WORD_W-1:0] k0, k1, k2, k3;
    logic [WORD_W-1:0] tmp_a;
    logic [WORD_W-1:0] tmp_b;
    logic [WORD_W-1:0] k_new;
    logic              z_bit;

    // Next key word: the newest word k3 mixes with k1 through two rotations,
    // then the oldest word k0 and the round constant are folded in.
    always_comb begin
        tmp_a = '0;
        tmp_b = '0;
        z_bit = 1'b0;
        k_new = '0;
        tmp_a = rotr(k3, 3) ^ k1;
        tmp_b = tmp_a ^ rotr(tmp_a, 1);
        z_bit = Z0[{1'b0, count}];
        k_new = k0 ^ tmp_b ^ C ^ {{(WORD_W-1){1'b0}}, z_bit};
    end

    // Key register bank: load overrides advancing; otherwise the words
    // shift down by one each round with the new word entering at k3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k0 <= '0;
            k1 <= '0;
            k2 <= '0;
            k3 <= '0;
        end else if (load) begin
            k3 <= key[63:48];
            k2 <= key[47:32];
            k1 <= key[31:16];
            k0 <= key[15:0];
        end else begin
            k0 <= k1;
            k1 <= k2;
            k2 <= k3;
            k3 <= k_new;
        end
    end

    assign round_key = k0;

endmodule

// File: rtl/simon_iterative_cipher_core.sv
// SIMON32/64 encryption core, one Feistel round per clock.
// After a load edge, 32 round edges with count = 0..31 leave the ciphertext
// in the state registers. Rounds run on every non-load edge; the controller
// decides when to stop clocking or reload.
// Ports:
//   clk, rst    - clock and asynchronous active-high reset
//   load        - capture plaintext and key (takes priority over a round)
//   plaintext   - {x,y}, x in [31:16]
//   key         - {k3,k2,k1,k0}
//   count       - round index for the round performed this cycle
//   ciphertext  - live {x,y} state
module simon_iterative_cipher_core
    import simon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] plaintext,
    input  logic [63:0] key,
    input  logic [4:0]  count,
    output logic [31:0] ciphertext
);

    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic [WORD_W-1:0] round_key;

    simon_key_schedule u_key_schedule (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .key       (key),
        .count     (count),
        .round_key (round_key)
    );

    // Feistel state: load takes the plaintext directly, otherwise the left
    // word absorbs f(x), the right word and the round key, and the old left
    // word moves right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= plaintext[31:16];
            y <= plaintext[15:0];
        end else begin
            x <= y ^ simon_f(x) ^ round_key;
            y <= x;
        end
    end

    assign ciphertext = {x, y};

endmodule

// File: tb/tb_simon_iterative_cipher_core.sv
// Self-checking bench for simon_iterative_cipher_core.
// Table of {plaintext, key, expected} records run through load + 32 rounds,
// plus hand-written sequences for load priority, single round, async reset
// mid-encryption and back-to-back loads.
module tb_simon_iterative_cipher_core;

    typedef struct {
        logic [31:0] pt;
        logic [63:0] k;
        logic [31:0] expected;
    } vec_t;

    localparam logic [31:0] STD_PT  = 32'h65656877;
    localparam logic [63:0] STD_KEY = 64'h1918111009080100;
    localparam logic [31:0] STD_CT  = 32'hc69be9bb;
    localparam int          NUM_VEC = 21;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] plaintext;
    logic [63:0] key;
    logic [4:0]  count;
    logic [31:0] ciphertext;

    int tests_run;
    int tests_failed;

    string z0_str = "11111010001001010110000111001101111101000100101011000011100110";

    vec_t vectors[NUM_VEC];

    simon_iterative_cipher_core dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .plaintext  (plaintext),
        .key        (key),
        .count      (count),
        .ciphertext (ciphertext)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] m_rol(input logic [15:0] w, input int n);
        logic [15:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
        return r;
    endfunction

    function automatic logic [15:0] m_ror(input logic [15:0] w, input int n);
        logic [15:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[0], r[15:1]};
        return r;
    endfunction

    // Whole-block software reference for SIMON32/64 encryption.
    function automatic logic [31:0] simon_model(input logic [31:0] pt, input logic [63:0] k);
        logic [15:0] mx, my, mt, tmp, kn;
        logic [15:0] ks[4];
        mx = pt[31:16];
        my = pt[15:0];
        ks[0] = k[15:0];
        ks[1] = k[31:16];
        ks[2] = k[47:32];
        ks[3] = k[63:48];
        for (int r = 0; r < 32; r++) begin
            mt = mx;
            mx = my ^ ((m_rol(mx, 1) & m_rol(mx, 8)) ^ m_rol(mx, 2)) ^ ks[0];
            my = mt;
            tmp = m_ror(ks[3], 3) ^ ks[1];
            tmp = tmp ^ m_ror(tmp, 1);
            kn = ~ks[0] ^ tmp ^ 16'h0003;
            if (z0_str[r] == "1") kn = kn ^ 16'h0001;
            ks[0] = ks[1];
            ks[1] = ks[2];
            ks[2] = ks[3];
            ks[3] = kn;
        end
        return {mx, my};
    endfunction

    // Drive one cycle's inputs at the falling edge, then wait until just
    // after the following rising edge so outputs can be sampled.
    task automatic applyStimulus(input logic ld, input logic [31:0] p,
                                 input logic [63:0] k, input logic [4:0] c);
        @(negedge clk);
        load      = ld;
        plaintext = p;
        key       = k;
        count     = c;
        @(posedge clk);
        #1;
    endtask

    task automatic runRounds();
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, plaintext, key, 5'(i));
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        load         = 1'b0;
        plaintext    = '0;
        key          = '0;
        count        = '0;

        vectors[0] = '{pt: STD_PT, k: STD_KEY, expected: STD_CT};
        for (int i = 1; i < NUM_VEC; i++) begin
            vectors[i].pt       = $urandom;
            vectors[i].k        = {$urandom, $urandom};
            vectors[i].expected = simon_model(vectors[i].pt, vectors[i].k);
        end

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_state", ciphertext, 32'h0);
        rst = 1'b0;

        // Load priority with a nonzero count, then one round, then the rest
        applyStimulus(1'b1, STD_PT, STD_KEY, 5'd5);
        checkOutput("load_priority", ciphertext, STD_PT);
        applyStimulus(1'b0, STD_PT, STD_KEY, 5'd0);
        checkOutput("single_round", ciphertext, 32'hBCA26565);
        for (int i = 1; i < 32; i++) applyStimulus(1'b0, STD_PT, STD_KEY, 5'(i));
        checkOutput("run_after_load_priority", ciphertext, STD_CT);

        // Table-driven vectors
        for (int v = 0; v < NUM_VEC; v++) begin
            applyStimulus(1'b1, vectors[v].pt, vectors[v].k, 5'd0);
            runRounds();
            checkOutput($sformatf("vector_%0d", v), ciphertext, vectors[v].expected);
        end

        // Async reset between edges in the middle of an encryption
        applyStimulus(1'b1, STD_PT, STD_KEY, 5'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, STD_PT, STD_KEY, 5'(i));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_immediate", ciphertext, 32'h0);
        @(negedge clk);
        checkOutput("mid_reset_held", ciphertext, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b1, STD_PT, STD_KEY, 5'd0);
        runRounds();
        checkOutput("after_reset_rerun", ciphertext, STD_CT);

        // Back-to-back: vector 1 completes, standard vector loads on the next edge
        applyStimulus(1'b1, vectors[1].pt, vectors[1].k, 5'd0);
        runRounds();
        checkOutput("b2b_first_result", ciphertext, vectors[1].expected);
        applyStimulus(1'b1, STD_PT, STD_KEY, 5'd0);
        checkOutput("b2b_second_load", ciphertext, STD_PT);
        runRounds();
        checkOutput("b2b_second_result", ciphertext, STD_CT);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/simon_iterative_cipher_core.md
Name: simon_iterative_cipher_core

Overview:
SIMON32/64 block-cipher encryption core built as one round per clock (iterative).
- Loads a 32-bit plaintext and a 64-bit key.
- Performs 32 Feistel rounds under an externally supplied 5-bit round counter, with an on-the-fly key schedule.
- Exposes the 32-bit state as ciphertext.
- Sits under a controller or bench that sequences load and count.

Parameters:
none. Word size 16, key words 4, rounds 32 are fixed by SIMON32/64; they are constants in the package, not parameters.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  when high, capture plaintext and key on the next rising edge
plaintext  input  32  block to encrypt; [31:16]=x (left word), [15:0]=y (right word)
key  input  64  key words k3..k0; [63:48]=k3, [47:32]=k2, [31:16]=k1, [15:0]=k0
count  input  5  round index i (0..31) for the round performed this cycle
ciphertext  output  32  current state {x,y}; valid as ciphertext after the round with count=31

Behaviour:
- Reset (async, rst=1): x, y, k0..k3 registers cleared to 0, so ciphertext=0. This applies mid-encryption too: all state is lost.
- Load priority: on a rising edge with load=1, set x<=plaintext[31:16], y<=plaintext[15:0], {k3,k2,k1,k0}<=key. No round occurs that cycle, and count is ignored.
- Round (rising edge, load=0) applies one round with round key k0:
  - f(x) = (rotl1(x) & rotl8(x)) ^ rotl2(x)
  - x <= y ^ f(x) ^ k0
  - y <= x
- Key schedule (same edge as the round):
  - tmp = rotr3(k3) ^ k1
  - tmp = tmp ^ rotr1(tmp)
  - knew = ~k0 ^ tmp ^ z0[count] ^ 16'h0003, equivalent to k0 ^ tmp ^ 16'hFFFC ^ z0bit
  - shift: k0<=k1, k1<=k2, k2<=k3, k3<=knew
- z0 sequence: 62 bits, index 0 first: 11111010001001010110000111001101111101000100101011000011100110. Only indices 0..31 are reachable through count.
- Timing: the load edge, followed by 32 round edges with count=0,1,...,31, gives the ciphertext. It is valid immediately after the 32nd round edge and holds until the next edge. Total 33 cycles from load edge to result.
- Rounds occur on every non-load edge; there is no enable and no done flag. The controller must assert load, or stop clocking, after round 31. Additional rounds continue to modify the state.
- count is sampled as-is; wrap from 31 to 0 needs no special handling.
- ciphertext is a direct combinational view of the {x,y} registers, with no extra register stage.
- All arithmetic is bitwise on 16-bit words; there are no carries.

Decomposition:
- Package simon_pkg holds:
  - WORD_W=16, KEY_WORDS=4, NUM_ROUNDS=32
  - Z0 as a 62-bit constant with index 0 = first sequence bit
  - the constant C=16'hFFFC
  - a function for f()
- Sub-module simon_key_schedule owns k0..k3 and the next-key logic. Inputs: clk, rst, load, key, count. Output: round_key=k0.
- The top module holds the x/y datapath and instantiates simon_key_schedule.

Test Plan:
- Standard vector: load plaintext=32'h65656877, key=64'h1918111009080100, then 32 rounds count 0..31 -> ciphertext=32'hc69be9bb.
- Single round: same load, one edge with count=0 -> ciphertext=32'hBCA26565.
- Reset: assert rst asynchronously mid-encryption (between edges) -> ciphertext=0 immediately. After release, a reload plus 32 rounds of the standard vector -> 32'hc69be9bb.
- Load priority: load=1 with count=5 -> ciphertext equals plaintext exactly. A 32-round run afterwards still yields the expected result.
- Back-to-back: the load edge for vector 2 immediately follows round 31 of vector 1 -> vector 1 result is visible for one cycle; vector 2 result is 32'hc69be9bb when vector 2 is the standard vector.
- Regression: 20 random plaintext/key pairs compared against a software SIMON32/64 model -> all match after the 32nd round.
